// File: rtl/shift_unit.sv
// -----------------------------------------------------------------------------
// shift_unit
//
// Multi-cycle iterative shifter/rotator for the datapath ALU. It takes an
// operand, a mode and a shift count, then walks the count down by up to STEP
// bit positions per clock until the count reaches zero. The control unit
// issues the operation with a one-cycle start and collects the result into Z
// when done pulses.
//
// Modes (mode[2:0]):
//   000 SHR   logical shift right, zero fill at the MSB
//   001 SHRA  arithmetic shift right, sign replicated at the MSB
//   010 SHL   logical shift left, zero fill at the LSB
//   011 ROR   rotate right
//   100 ROL   rotate left
//   others    pass-through: result = operand, carry_out = 0
//
// Ports:
//   clock      in   system clock; all state changes on the rising edge
//   clear      in   synchronous active-high reset; aborts any operation
//   start      in   request; sampled only in IDLE
//   mode       in   [2:0] operation select, latched at acceptance
//   operand    in   [WIDTH-1:0] value to shift, latched at acceptance
//   amount     in   [AMT_W-1:0] shift count (count mod WIDTH)
//   busy       out  high while in SHIFT or DONE
//   done       out  one-cycle pulse; result and carry_out are valid
//   result     out  [WIDTH-1:0] shifted value, held until the next
//                   accepted start or clear
//   carry_out  out  last bit shifted out (shifts) or wrapped (rotates)
// -----------------------------------------------------------------------------
module shift_unit #(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 1,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] operand,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    M_SHR  = 3'b000,
    M_SHRA = 3'b001,
    M_SHL  = 3'b010,
    M_ROR  = 3'b011,
    M_ROL  = 3'b100
  } mode_t;

  state_t           state;
  logic [2:0]       mode_q;
  logic [AMT_W-1:0] remaining;

  // Combinational result of one SHIFT cycle.
  logic [WIDTH-1:0] step_result;
  logic             step_carry;
  logic [AMT_W-1:0] step_count;

  // Mode codes above ROL are defined as pass-through, not as errors.
  function automatic logic mode_valid(input logic [2:0] m);
    return (m <= M_ROL);
  endfunction

  // One bit position of the latched operation. Packs {carry, value} so the
  // caller can chain STEP of these per clock; the carry of the final link is
  // the last bit that left the word in that cycle.
  function automatic logic [WIDTH:0] shift_one(input logic [2:0]       m,
                                               input logic [WIDTH-1:0] v);
    logic [WIDTH:0] r;
    case (m)
      M_SHR:   r = {v[0],       1'b0,          v[WIDTH-1:1]};
      M_SHRA:  r = {v[0],       v[WIDTH-1],    v[WIDTH-1:1]};
      M_SHL:   r = {v[WIDTH-1], v[WIDTH-2:0],  1'b0};
      M_ROR:   r = {v[0],       v[0],          v[WIDTH-1:1]};
      M_ROL:   r = {v[WIDTH-1], v[WIDTH-2:0],  v[WIDTH-1]};
      default: r = {1'b0,       v};
    endcase
    return r;
  endfunction

  // Apply n = min(STEP, remaining) single-bit steps. The loop unrolls into a
  // STEP-deep chain of muxes; links past the remaining count pass through.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    step_result = result;
    step_carry  = carry_out;
    step_count  = '0;
    for (int i = 0; i < STEP; i++) begin
      if (AMT_W'(i) < remaining) begin
        {step_carry, step_result} = shift_one(mode_q, step_result);
        step_count                = step_count + 1'b1;
      end
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement
    // order.
    if (clear) begin
      state     <= IDLE;
      mode_q    <= M_SHR;
      remaining <= '0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            result    <= operand;
            mode_q    <= mode;
            remaining <= amount;
            carry_out <= 1'b0;
            // A zero count or an invalid mode has nothing to iterate, so it
            // skips SHIFT and reports the latched operand unchanged.
            if ((amount == '0) || !mode_valid(mode)) begin
              state <= DONE;
            end else begin
              state <= SHIFT;
            end
          end
        end

        SHIFT: begin
          result    <= step_result;
          carry_out <= step_carry;
          remaining <= remaining - step_count;
          if (remaining == step_count) begin
            state <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Pure decodes of the state register, so both are glitch-free.
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: doc/shift_unit.md
Name: shift_unit

Overview:
- Multi-cycle iterative shifter/rotator for the datapath ALU. Generalises the single-mode SHRA path to WIDTH-bit operands and five shift/rotate modes.
- Configurable throughput: STEP bit positions per clock.
- Start/done handshake, so the control unit can issue the operation in one T-state and collect the result into Z when done asserts.
- Also reports the last bit shifted out.

Parameters:
WIDTH, 32, operand/result width in bits; must be a power of 2, 8..64.
STEP, 1, max bit positions shifted per clock; must be a power of 2, 1..WIDTH.
AMT_W, derived $clog2(WIDTH), shift-amount width (localparam, not overridable).

Ports:
clock  in  1  system clock; all state changes on rising edge.
clear  in  1  synchronous active-high reset.
start  in  1  request; sampled only in IDLE.
mode  in  3  000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL, others invalid.
operand  in  WIDTH  value to shift (Y-side operand).
amount  in  AMT_W  shift count; the caller passes the low AMT_W bits of the register (count mod WIDTH).
busy  out  1  high in SHIFT and DONE.
done  out  1  one-cycle pulse; result and carry_out are valid.
result  out  WIDTH  shifted value; held until the next accepted start or clear.
carry_out  out  1  last bit shifted out (shifts) or last bit wrapped (rotates).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. The clock port is `clock` and the reset port is `clear`.
- Reset values: on a rising edge with clear=1:
  - state=IDLE, busy=0, done=0, result=0, carry_out=0, internal remaining count=0.
  - clear overrides start and any in-flight operation (reset mid-operation aborts it, and no done is issued).
- States: IDLE, SHIFT, DONE. busy = (state != IDLE); done = (state == DONE). Both are registered-state decodes, so they are glitch-free.
- IDLE:
  - start=0: stay.
  - start=1: latch operand into result, latch mode, latch remaining=amount, clear carry_out.
  - If amount==0 or mode is invalid: go to DONE, with result=operand and carry_out=0.
  - Otherwise go to SHIFT.
- SHIFT: each edge, n = min(STEP, remaining); apply n positions to result; remaining -= n.
  - If the new remaining==0: go to DONE, else stay.
  - carry_out updates every step to the last bit leaving the word in that step.
- Per-mode rules for one step of n positions:
  - SHR: zero fill at the MSB; carry = result[n-1].
  - SHRA: replicate result[WIDTH-1] into the top n bits; carry = result[n-1].
  - SHL: zero fill at the LSB; carry = result[WIDTH-n].
  - ROR: bits leaving the LSB enter at the MSB; carry = result[n-1].
  - ROL: bits leaving the MSB enter at the LSB; carry = result[WIDTH-n].
- DONE: done=1 for exactly one cycle, then return unconditionally to IDLE. A start asserted during DONE is ignored.
- Latency: done is high in the cycle after edge max(1, ceil(amount/STEP)) following the accepting edge.
- Busy behaviour: start while busy is ignored; no queueing. operand, amount and mode may change freely after acceptance; the latched copies are used.
- result and carry_out stay stable from DONE through IDLE until the next accepted start or clear.
- All arithmetic is unsigned except the SHRA sign replication. No X-propagation: invalid mode is a defined pass-through.

Test Plan:
- WIDTH=32, STEP=1, SHRA, operand=0xFFFFFF0A, amount=7 -> done 7 edges after accept; result=0xFFFFFFFE, carry_out=0, busy high for the 7 cycles in between.
- Same stimulus with STEP=4 -> done after 2 edges; result=0xFFFFFFFE, carry_out=0.
- ROR 0x80000001 by 1 -> result 0xC0000000, carry_out=1. ROL 0x80000001 by 4 -> result 0x00000018, carry_out=0. SHL 0x00000001 by 31 -> result 0x80000000, carry_out=0.
- amount=0 (SHR, operand 0x12345678), then mode=111 with amount=5 -> each yields done 1 edge after accept, result=operand, carry_out=0.
- SHR 0xF0000000 by 20 with STEP=1:
  - Pulse start again at cycle 3 with a different operand -> ignored; final result 0x00000F00.
  - Assert clear at cycle 10 of a new run -> next cycle busy=0, result=0, no done pulse.
- Back-to-back: start held high continuously -> operations accept on the IDLE cycles only. Each done pulse lasts exactly one cycle, and there is at least one IDLE cycle between consecutive done pulses.
